dp_norm_shift_seq: RTL and testbench

Multi-cycle normalizer for double-precision results, sitting directly upstream of the DP rounding stage in the FP execution unit. It accepts a raw sign, a signed biased exponent and a 57-bit unnormalized mantissa with guard/round/sticky from the adder, multiplier or FMA datapath. It iteratively shifts the mantissa until normal, subnormal, zero or overflow, then presents the packed 65-bit exponent/fraction word, the 3 guard bits and the sign that the rounding stage consumes. Left and denormalizing right shifts advance at most 8 positions per cycle, bounding the shifter width.

---
 rtl/dp_norm_shift_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_dp_norm_shift_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_norm_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : dp_norm_shift_seq
// Description : Multi-cycle binary64 normalizer feeding the DP rounding stage.
//               It takes a raw sign, a 13-bit signed biased exponent and a
//               57-bit mantissa (carry, hidden, fraction, guard/round/sticky).
//               The mantissa is shifted a bounded amount per cycle until the
//               result is normal, subnormal, zero or overflowed. It then
//               presents {2'b00, exp, frac}, the guard bits and the sign.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_norm_shift_seq (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        VALID_IN,
    output logic        READY_IN,
    input  logic        SIGN_IN,
    input  logic [12:0] EXP_IN,
    input  logic [56:0] MANT_IN,
    output logic        VALID_OUT,
    input  logic        READY_OUT,
    output logic        SIGN_OUT,
    output logic [64:0] EXP_FRAC,
    output logic [2:0]  GUARD_BITS,
    output logic        OVERFLOW
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic signed [13:0] c_E_ONE  = 14'sd1;
    localparam logic signed [13:0] c_E_MAX  = 14'sd2047;
    localparam logic signed [13:0] c_D_JAM  = 14'sd64;
    localparam logic signed [13:0] c_D_STEP = 14'sd8;

    state_t              r_state;
    state_t              w_state_nxt;

    // Working mantissa and exponent. The exponent is one bit wider than the
    // input, so that the increments from carry and denormalization cannot wrap.
    logic [56:0]         r_m;
    logic signed [13:0]  r_e;
    logic                r_sign;
    logic [56:0]         w_m_nxt;
    logic signed [13:0]  w_e_nxt;

    // Output registers, loaded only on the finalize step
    logic [64:0]         r_exp_frac;
    logic [2:0]          r_guard;
    logic                r_sign_out;
    logic                r_ovf;

    logic                w_accept;
    logic                w_fin;
    logic [10:0]         w_fin_exp;
    logic [51:0]         w_fin_frac;
    logic [2:0]          w_fin_guard;
    logic                w_fin_ovf;

    // Right-shift (denormalize) datapath
    logic signed [13:0]  w_dist;
    logic [3:0]          w_rsh_amt;
    logic [56:0]         w_rsh_mask;
    logic [56:0]         w_rsh_m;
    logic                w_rsh_sticky;

    // Left-shift (normalize) datapath
    logic [3:0]          w_lzc;
    logic signed [13:0]  w_e_room;
    logic [3:0]          w_lsh_amt;

    // Carry-out correction: one position right, with the lost bit jammed into sticky
    logic [56:0]         w_carry_m;

    // Leading-zero count of one byte; an all-zero byte returns 8
    function automatic logic [3:0] f_lzc8(input logic [7:0] b);
        logic [3:0] n;
        casez (b)
            8'b1???????: n = 4'd0;
            8'b01??????: n = 4'd1;
            8'b001?????: n = 4'd2;
            8'b0001????: n = 4'd3;
            8'b00001???: n = 4'd4;
            8'b000001??: n = 4'd5;
            8'b0000001?: n = 4'd6;
            8'b00000001: n = 4'd7;
            default:     n = 4'd8;
        endcase
        return n;
    endfunction

    assign w_accept     = (r_state == S_IDLE) && VALID_IN;

    // Distance to the minimum normal exponent. It is only meaningful when E < 1,
    // so the distance is then at least 1.
    assign w_dist       = c_E_ONE - r_e;
    assign w_rsh_amt    = (w_dist > c_D_STEP) ? 4'd8 : w_dist[3:0];
    assign w_rsh_mask   = (57'd1 << w_rsh_amt) - 57'd1;
    assign w_rsh_m      = r_m >> w_rsh_amt;
    assign w_rsh_sticky = |(r_m & w_rsh_mask);

    // The left shift never takes E below 1. This path runs only when E >= 2,
    // so the room is at least 1.
    assign w_lzc        = f_lzc8(r_m[55:48]);
    assign w_e_room     = r_e - c_E_ONE;
    assign w_lsh_amt    = (w_e_room < $signed({10'd0, w_lzc})) ? w_e_room[3:0] : w_lzc;

    assign w_carry_m    = {1'b0, r_m[56:2], r_m[1] | r_m[0]};

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and one normalization step per cycle. In NORM, the first rule that matches wins.
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_e_nxt     = r_e;
        w_fin       = 1'b0;
        w_fin_exp   = 11'd0;
        w_fin_frac  = r_m[54:3];
        w_fin_guard = r_m[2:0];
        w_fin_ovf   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (VALID_IN) begin
                    w_m_nxt     = MANT_IN;
                    w_e_nxt     = {EXP_IN[12], EXP_IN};
                    w_state_nxt = S_NORM;
                end
            end

            S_NORM: begin
                if (r_m == 57'd0) begin
                    w_fin       = 1'b1;
                    w_fin_frac  = 52'd0;
                    w_fin_guard = 3'd0;
                end else if (r_m[56]) begin
                    w_m_nxt = w_carry_m;
                    w_e_nxt = r_e + c_E_ONE;
                end else if (r_e < c_E_ONE) begin
                    if (w_dist > c_D_JAM) begin
                        // All bits are lost. Only a nonzero marker survives in sticky.
                        w_m_nxt = {56'd0, |r_m};
                        w_e_nxt = c_E_ONE;
                    end else begin
                        w_m_nxt = {w_rsh_m[56:1], w_rsh_m[0] | w_rsh_sticky};
                        w_e_nxt = r_e + $signed({10'd0, w_rsh_amt});
                    end
                end else if (r_e >= c_E_MAX) begin
                    w_fin       = 1'b1;
                    w_fin_exp   = 11'h7FF;
                    w_fin_frac  = 52'd0;
                    w_fin_guard = 3'd0;
                    w_fin_ovf   = 1'b1;
                end else if (r_m[55]) begin
                    w_fin       = 1'b1;
                    w_fin_exp   = r_e[10:0];
                end else if (r_e == c_E_ONE) begin
                    w_fin       = 1'b1;
                    w_fin_exp   = 11'd0;
                end else begin
                    w_m_nxt = r_m << w_lsh_amt;
                    w_e_nxt = r_e - $signed({10'd0, w_lsh_amt});
                end

                if (w_fin) begin
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                if (READY_OUT) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Work registers and output registers. The outputs change only on finalize, so they hold through DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_m        <= 57'd0;
            r_e        <= 14'sd0;
            r_sign     <= 1'b0;
            r_exp_frac <= 65'd0;
            r_guard    <= 3'd0;
            r_sign_out <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_m <= w_m_nxt;
            r_e <= w_e_nxt;
            if (w_accept) begin
                r_sign <= SIGN_IN;
            end
            if (w_fin) begin
                r_exp_frac <= {2'b00, w_fin_exp, w_fin_frac};
                r_guard    <= w_fin_guard;
                r_sign_out <= r_sign;
                r_ovf      <= w_fin_ovf;
            end
        end
    end

    assign READY_IN   = (r_state == S_IDLE);
    assign VALID_OUT  = (r_state == S_DONE);
    assign SIGN_OUT   = r_sign_out;
    assign EXP_FRAC   = r_exp_frac;
    assign GUARD_BITS = r_guard;
    assign OVERFLOW   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dp_norm_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_norm_shift_seq
// Description : Self-checking bench for dp_norm_shift_seq. It runs directed
//               cases, then randomized operands checked against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_norm_shift_seq;

    logic        CLK;
    logic        RESET;
    logic        VALID_IN;
    logic        READY_IN;
    logic        SIGN_IN;
    logic [12:0] EXP_IN;
    logic [56:0] MANT_IN;
    logic        VALID_OUT;
    logic        READY_OUT;
    logic        SIGN_OUT;
    logic [64:0] EXP_FRAC;
    logic [2:0]  GUARD_BITS;
    logic        OVERFLOW;

    int checks = 0;
    int errors = 0;

    dp_norm_shift_seq dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .VALID_IN   (VALID_IN),
        .READY_IN   (READY_IN),
        .SIGN_IN    (SIGN_IN),
        .EXP_IN     (EXP_IN),
        .MANT_IN    (MANT_IN),
        .VALID_OUT  (VALID_OUT),
        .READY_OUT  (READY_OUT),
        .SIGN_OUT   (SIGN_OUT),
        .EXP_FRAC   (EXP_FRAC),
        .GUARD_BITS (GUARD_BITS),
        .OVERFLOW   (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Shift right by d. Every bit that falls off is ORed into bit 0.
    function automatic logic [56:0] jam_shift(input logic [56:0] v, input int d);
        logic [56:0] r;
        logic        st;
        if (d >= 57) return {56'd0, |v};
        st = 1'b0;
        for (int i = 0; i < d; i++) st = st | v[i];
        r = v >> d;
        r[0] = r[0] | st;
        return r;
    endfunction

    // Reference model: the result is derived from the total shift amounts. The step count follows from the 8-per-cycle bound.
    task automatic ref_model(input int e_in, input logic [56:0] m_in,
                             output logic [64:0] x_ef, output logic [2:0] x_g,
                             output logic x_ovf, output int x_n);
        int          e;
        int          d;
        int          p;
        int          s;
        logic [56:0] mm;
        logic [10:0] xe;
        e = e_in; mm = m_in; x_n = 0; x_ovf = 1'b0;
        if (mm == 57'd0) begin
            x_ef = 65'd0; x_g = 3'd0;
            return;
        end
        if (mm[56]) begin
            mm = jam_shift(mm, 1);
            e  = e + 1;
            x_n++;
        end
        if (e < 1) begin
            d   = 1 - e;
            x_n = x_n + ((d > 64) ? 1 : (d + 7) / 8);
            mm  = jam_shift(mm, d);
            e   = 1;
        end
        if (e >= 2047) begin
            x_ef  = {2'b00, 11'h7FF, 52'd0};
            x_g   = 3'd0;
            x_ovf = 1'b1;
            return;
        end
        p = 0;
        for (int i = 0; i < 57; i++) if (mm[i]) p = i;
        s   = ((55 - p) <= (e - 1)) ? (55 - p) : (e - 1);
        x_n = x_n + (s + 7) / 8;
        mm  = mm << s;
        e   = e - s;
        xe  = mm[55] ? 11'(e) : 11'd0;
        x_ef = {2'b00, xe, mm[54:3]};
        x_g  = mm[2:0];
    endtask

    // One complete transaction: accept, wait for VALID_OUT, check the result, hold for `hold` cycles, then release.
    task automatic run_op(input logic s, input int e, input logic [56:0] m, input int hold,
                          output logic [64:0] o_ef, output logic [2:0] o_g,
                          output logic o_ovf, output logic o_s, output int o_edge);
        logic [64:0] x_ef;
        logic [2:0]  x_g;
        logic        x_ovf;
        int          x_n;
        int          lat;
        ref_model(e, m, x_ef, x_g, x_ovf, x_n);
        @(negedge CLK);
        chkb("ready_in_idle", READY_IN, 1'b1);
        SIGN_IN  = s;
        EXP_IN   = 13'(e);
        MANT_IN  = m;
        VALID_IN = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        SIGN_IN  = ~s;
        MANT_IN  = {25'd0, $urandom};
        chkb("ready_in_busy", READY_IN, 1'b0);
        lat = 0;
        while (VALID_OUT !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        o_edge = lat + 1;
        o_ef   = EXP_FRAC;
        o_g    = GUARD_BITS;
        o_ovf  = OVERFLOW;
        o_s    = SIGN_OUT;
        if (VALID_OUT !== 1'b1) begin
            chkb("valid_timeout", VALID_OUT, 1'b1);
            RESET = 1'b1;
            @(negedge CLK);
            RESET = 1'b0;
            return;
        end
        chki("valid_edge", o_edge, x_n + 2);
        chk ("exp_frac", EXP_FRAC, x_ef);
        chk ("guard", 65'(GUARD_BITS), 65'(x_g));
        chkb("overflow", OVERFLOW, x_ovf);
        chkb("sign", SIGN_OUT, s);
        chkb("ready_in_done", READY_IN, 1'b0);
        for (int i = 0; i < hold; i++) begin
            VALID_IN = 1'b1;
            EXP_IN   = 13'($urandom);
            MANT_IN  = {25'd0, $urandom};
            @(posedge CLK); #1;
            chkb("hold_valid", VALID_OUT, 1'b1);
            chkb("hold_ready_in", READY_IN, 1'b0);
            chk ("hold_exp_frac", EXP_FRAC, x_ef);
            chk ("hold_guard", 65'(GUARD_BITS), 65'(x_g));
            chkb("hold_overflow", OVERFLOW, x_ovf);
            chkb("hold_sign", SIGN_OUT, s);
        end
        VALID_IN  = 1'b0;
        READY_OUT = 1'b1;
        @(posedge CLK); #1;
        READY_OUT = 1'b0;
        chkb("release_valid", VALID_OUT, 1'b0);
        chkb("release_ready_in", READY_IN, 1'b1);
    endtask

    logic [64:0] ef;
    logic [2:0]  g;
    logic        ov;
    logic        sg;
    int          ve;
    int          re;
    logic [56:0] rm;
    logic [63:0] r64;
    int          rp;

    initial begin
        RESET = 1'b1; VALID_IN = 1'b0; READY_OUT = 1'b0;
        SIGN_IN = 1'b0; EXP_IN = 13'd0; MANT_IN = 57'd0;
        repeat (3) @(posedge CLK);
        #1;
        chkb("rst_ready_in", READY_IN, 1'b1);
        chkb("rst_valid_out", VALID_OUT, 1'b0);
        chk ("rst_exp_frac", EXP_FRAC, 65'd0);
        chk ("rst_guard", 65'(GUARD_BITS), 65'd0);
        chkb("rst_sign", SIGN_OUT, 1'b0);
        chkb("rst_overflow", OVERFLOW, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;

        // Normal input
        run_op(1'b0, 1023, (57'd1 << 55) | 57'd5, 0, ef, g, ov, sg, ve);
        chk ("normal_ef", ef, {2'b00, 11'd1023, 52'd0});
        chk ("normal_guard", 65'(g), 65'(3'b101));
        chki("normal_edge", ve, 2);

        // Carry input, held 5 cycles in DONE
        run_op(1'b1, 1023, (57'd1 << 56) | 57'd1, 5, ef, g, ov, sg, ve);
        chk ("carry_ef", ef, {2'b00, 11'd1024, 52'd0});
        chk ("carry_guard", 65'(g), 65'(3'b001));
        chki("carry_edge", ve, 3);

        // Long left shift
        run_op(1'b0, 1000, 57'd1 << 35, 0, ef, g, ov, sg, ve);
        chk ("long_ef", ef, {2'b00, 11'd980, 52'd0});
        chk ("long_guard", 65'(g), 65'd0);
        chki("long_edge", ve, 5);

        // Subnormal stops
        run_op(1'b0, 5, 57'd1 << 40, 0, ef, g, ov, sg, ve);
        chk ("sub1_ef", ef, {2'b00, 11'd0, (52'd1 << 41)});
        chkb("sub1_ovf", ov, 1'b0);
        run_op(1'b1, -2, 57'd1 << 55, 0, ef, g, ov, sg, ve);
        chk ("sub2_ef", ef, {2'b00, 11'd0, (52'd1 << 49)});
        chk ("sub2_guard", 65'(g), 65'd0);

        // Overflow and zero
        run_op(1'b0, 2047, 57'd1 << 55, 0, ef, g, ov, sg, ve);
        chk ("ovf_ef", ef, {2'b00, 11'h7FF, 52'd0});
        chkb("ovf_flag", ov, 1'b1);
        run_op(1'b1, 100, 57'd0, 2, ef, g, ov, sg, ve);
        chk ("zero_ef", ef, 65'd0);
        chkb("zero_sign", sg, 1'b1);

        // Reset during the third NORM cycle of an 8-step denormalization (D=63)
        @(negedge CLK);
        SIGN_IN = 1'b1; EXP_IN = 13'(-62); MANT_IN = 57'd1 << 55; VALID_IN = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        @(posedge CLK);
        @(posedge CLK); #1;
        chkb("pre_rst_valid", VALID_OUT, 1'b0);
        chkb("pre_rst_ready_in", READY_IN, 1'b0);
        RESET = 1'b1;
        #1;
        chkb("async_rst_valid", VALID_OUT, 1'b0);
        chkb("async_rst_ready_in", READY_IN, 1'b1);
        chk ("async_rst_ef", EXP_FRAC, 65'd0);
        @(negedge CLK);
        RESET = 1'b0;
        run_op(1'b0, 1023, 57'd1 << 55, 0, ef, g, ov, sg, ve);
        chk ("post_rst_ef", ef, {2'b00, 11'd1023, 52'd0});

        // Randomized operands
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 3))
                0:       re = int'($urandom_range(1, 2046));
                1:       re = -int'($urandom_range(0, 80));
                2:       re = int'($urandom_range(2035, 2060));
                default: re = int'($urandom_range(0, 8191)) - 4096;
            endcase
            if ($urandom_range(0, 15) == 0) begin
                rm = 57'd0;
            end else begin
                r64 = {$urandom, $urandom};
                rm  = r64[56:0];
                rp  = int'($urandom_range(0, 56));
                for (int i = rp + 1; i < 57; i++) rm[i] = 1'b0;
                rm[rp] = 1'b1;
            end
            run_op(1'($urandom), re, rm, int'($urandom_range(0, 2)), ef, g, ov, sg, ve);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
